sn74ls197_sched: RTL and testbench
==================================

Name: sn74ls197_sched

Overview:
- Round-robin scheduler sharing one external sn74ls197 4-bit ripple counter between NREQ requesters.
- Each requester asks for one terminal-count run from its own 4-bit preset.
- The block holds the counter cleared when idle, loads the winner's preset, and pulses clk1 until the counter reads 4'hF. It then signals done to that requester.
- Board wiring is fixed: counter q[0] drives counter clk2, so ctr_clk1 advances the full 4-bit count.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LOAD_CYC, 2, cycles ctr_load is held low.
- SETTLE, 4, wait cycles after each load or tick before sampling ctr_q. Integrator sets it so SETTLE × clock period ≥ worst-case counter ripple delay.

Ports:
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  asynchronous active-low reset.
- req  in  NREQ  level request, held until done.
- preset  in  4*NREQ  preset for requester i at [4i+3:4i]. Sampled at grant.
- gnt  out  NREQ  one-hot grant, high from grant to done/abort.
- done  out  NREQ  one-cycle pulse to the granted requester.
- busy  out  1  high in any state other than IDLE.
- ctr_d  out  4  counter parallel data.
- ctr_load  out  1  counter load, active low.
- ctr_clr  out  1  counter clear, active low.
- ctr_clk1  out  1  counter clock. Idles high; each falling edge is one count.
- ctr_q  in  4  counter outputs.

Behaviour:
- Reset (clr=0, async): state=IDLE, gnt=0, done=0, busy=0, ctr_d=0, ctr_load=1, ctr_clr=0, ctr_clk1=1, rr pointer=0.
- IDLE
  - ctr_clr=0, holding the counter at 0.
  - If any req is set, grant the first set bit searching upward from (last+1) mod NREQ.
  - Latch that preset into ctr_d, raise gnt[i], go to LOAD.
  - Request-to-gnt latency: 1 cycle.
- LOAD: ctr_clr=1, ctr_load=0 for LOAD_CYC cycles. ctr_load returns to 1 on exit. Go to SETTLE.
- SETTLE: wait SETTLE cycles, outputs static. Go to CHECK.
- CHECK (1 cycle)
  - If ctr_q==4'hF, go to DONE.
  - Otherwise go to TICK: ctr_clk1=0 for exactly 1 cycle, then back to 1, then SETTLE again.
- DONE (1 cycle): done[i]=1, gnt[i] drops next cycle, last=i, return to IDLE.
- Tick count per run = 15-preset. Preset 4'hF needs no ticks.
- done timing with default parameters: done asserts in cycle 8+6*(15-p) after req is first sampled.
- Abort:
  - If req[i] drops while granted (any state except DONE), go to IDLE next cycle, gnt=0, no done pulse.
  - Pointer still updates to i.
- Simultaneous requests: the round-robin pointer guarantees no requester waits more than NREQ-1 runs.
- req changes by non-granted requesters during a run are ignored until IDLE.
- Mid-run preset changes are ignored; preset is latched at grant.
- Async reset mid-run returns all outputs to reset values immediately.

Optional Feature:
- Macro SN74LS197_SCHED_TIMEOUT_EN.
- When defined:
  - Adds output err (out, 1).
  - A 5-bit tick counter increments on each TICK.
  - If CHECK sees ctr_q≠4'hF after 16 ticks, err pulses 1 cycle and the block aborts to IDLE without done. Pointer updates.
- When undefined: no err port and no tick counter. A stuck counter holds the grant indefinitely.

Decomposition:
- Shared include sn74ls197_sched_defs.vh holds state encodings (IDLE, LOAD, SETTLE, CHECK, TICK, DONE) and the terminal-count constant 4'hF.
- One sub-module, rr_arbiter (parameter NREQ): inputs req, last, enable; outputs one-hot gnt_next and index.
- Counter timers and the FSM stay in the top module.

Test Plan:
- Reset then req=2'b01, preset0=4'hF: gnt[0] in cycle 1, ctr_load low cycles 1–2, zero clk1 falling edges, done[0] in cycle 8.
- req=2'b01, preset0=4'hC, model counter attached: exactly 3 falling edges on ctr_clk1, done[0] in cycle 26, ctr_q=4'hF at done.
- req=2'b11 held, both presets 4'hE: grants alternate 0,1,0,1 over 4 runs, never two consecutive to the same index.
- req[0] dropped after the second tick: gnt=0 next cycle, no done, ctr_clr=0 in IDLE; a pending req[1] is granted next.
- clr asserted during TICK: all outputs at reset values within the same cycle, ctr_clk1=1; normal run after release.
- With SN74LS197_SCHED_TIMEOUT_EN and ctr_q forced to 4'h0: err pulse after the 16th tick, no done, busy=0 next cycle.

Source files
------------

// File: rtl/sn74ls197_sched_pkg.sv
// Shared definitions for the sn74ls197 run scheduler: FSM encodings, terminal count,
// timeout limit and the round-robin slot helper.
package sn74ls197_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_TICK   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [3:0] TERM_CNT   = 4'hF;
  localparam logic [4:0] TICK_LIMIT = 5'd16;

  // Slot visited at step k of a search that starts just after the last winner.
  function automatic int rr_slot(input int last, input int k, input int n);
    return (last + k) % n;
  endfunction

endpackage

// File: rtl/sn74ls197_sched_rr_arbiter.sv
// Round-robin pick: first set request searching upward from (last+1) mod NREQ.
// Purely combinational; gnt_next is all-zero when disabled or nothing is requesting.
module rr_arbiter
  import sn74ls197_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  input  logic            i_enable,
  output logic [NREQ-1:0] o_gnt_next,
  output logic [IW-1:0]   o_index
);

  logic w_found;

  always_comb begin
    o_gnt_next = '0;
    o_index    = '0;
    w_found    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (i_enable && !w_found && i_req[rr_slot(int'(i_last), k, NREQ)]) begin
        w_found                                    = 1'b1;
        o_gnt_next[rr_slot(int'(i_last), k, NREQ)] = 1'b1;
        o_index                                    = IW'(rr_slot(int'(i_last), k, NREQ));
      end
    end
  end

endmodule

// File: rtl/sn74ls197_sched.sv
// Shares one sn74ls197 ripple counter between NREQ requesters: load preset, tick to 4'hF, signal done.
// Optional stuck-counter timeout (err output) under SN74LS197_SCHED_TIMEOUT_EN.
module sn74ls197_sched
  import sn74ls197_sched_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LOAD_CYC = 2,
  parameter int SETTLE   = 4
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic [NREQ-1:0]   i_req,
  input  logic [4*NREQ-1:0] i_preset,
  output logic [NREQ-1:0]   o_gnt,
  output logic [NREQ-1:0]   o_done,
  output logic              o_busy,
  output logic [3:0]        o_ctr_d,
  output logic              o_ctr_load,
  output logic              o_ctr_clr,
  output logic              o_ctr_clk1,
`ifdef SN74LS197_SCHED_TIMEOUT_EN
  output logic              o_err,
`endif
  input  logic [3:0]        i_ctr_q
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TMAX = (LOAD_CYC > SETTLE) ? LOAD_CYC : SETTLE;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] LOAD_INIT   = TW'(LOAD_CYC - 1);
  localparam logic [TW-1:0] SETTLE_INIT = TW'(SETTLE - 1);

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [IW-1:0]   r_last, w_last_nxt;
  logic [3:0]      r_ctr_d, w_ctr_d_nxt;
  logic [NREQ-1:0] r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_ctr_load, w_ctr_load_nxt;
  logic            r_ctr_clr, w_ctr_clr_nxt;
  logic            r_ctr_clk1, w_ctr_clk1_nxt;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
  logic [4:0]      r_tick, w_tick_nxt;
  logic            r_err, w_err_nxt;
`endif

  logic [NREQ-1:0] w_arb_gnt;
  logic [IW-1:0]   w_arb_idx;
  logic            w_req_held;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req      (i_req),
    .i_last     (r_last),
    .i_enable   (r_state == ST_IDLE),
    .o_gnt_next (w_arb_gnt),
    .o_index    (w_arb_idx)
  );

  // Only the granted requester's line matters once a run is under way.
  assign w_req_held = |(i_req & r_gnt);

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_ctr_d_nxt = r_ctr_d;
    w_done_nxt  = '0;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
    w_tick_nxt  = r_tick;
    w_err_nxt   = 1'b0;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (|w_arb_gnt) begin
          w_state_nxt = ST_LOAD;
          w_gnt_nxt   = w_arb_gnt;
          w_idx_nxt   = w_arb_idx;
          w_ctr_d_nxt = i_preset[4*int'(w_arb_idx) +: 4];
          w_timer_nxt = LOAD_INIT;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
          w_tick_nxt  = '0;
`endif
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_last_nxt  = r_idx;
      end
      default: begin
        if (!w_req_held) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
          w_last_nxt  = r_idx;
        end else begin
          case (r_state)
            ST_LOAD: begin
              if (r_timer == '0) begin
                w_state_nxt = ST_SETTLE;
                w_timer_nxt = SETTLE_INIT;
              end else begin
                w_timer_nxt = r_timer - TW'(1);
              end
            end
            ST_SETTLE: begin
              if (r_timer == '0) begin
                w_state_nxt = ST_CHECK;
              end else begin
                w_timer_nxt = r_timer - TW'(1);
              end
            end
            ST_CHECK: begin
              if (i_ctr_q == TERM_CNT) begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = r_gnt;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
              end else if (r_tick >= TICK_LIMIT) begin
                // A healthy run never needs more than 15 ticks.
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
                w_last_nxt  = r_idx;
                w_err_nxt   = 1'b1;
`endif
              end else begin
                w_state_nxt = ST_TICK;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
                w_tick_nxt  = r_tick + 5'd1;
`endif
              end
            end
            ST_TICK: begin
              w_state_nxt = ST_SETTLE;
              w_timer_nxt = SETTLE_INIT;
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_gnt_nxt   = '0;
            end
          endcase
        end
      end
    endcase

    // Counter pins are registered copies of the next-state decode so they never glitch.
    w_ctr_load_nxt = (w_state_nxt != ST_LOAD);
    w_ctr_clr_nxt  = (w_state_nxt != ST_IDLE);
    w_ctr_clk1_nxt = (w_state_nxt != ST_TICK);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_timer    <= '0;
      r_gnt      <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_ctr_d    <= '0;
      r_done     <= '0;
      r_busy     <= 1'b0;
      r_ctr_load <= 1'b1;
      r_ctr_clr  <= 1'b0;
      r_ctr_clk1 <= 1'b1;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
      r_tick     <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_timer    <= w_timer_nxt;
      r_gnt      <= w_gnt_nxt;
      r_idx      <= w_idx_nxt;
      r_last     <= w_last_nxt;
      r_ctr_d    <= w_ctr_d_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_ctr_load <= w_ctr_load_nxt;
      r_ctr_clr  <= w_ctr_clr_nxt;
      r_ctr_clk1 <= w_ctr_clk1_nxt;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
      r_tick     <= w_tick_nxt;
      r_err      <= w_err_nxt;
`endif
    end
  end

  assign o_gnt      = r_gnt;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_ctr_d    = r_ctr_d;
  assign o_ctr_load = r_ctr_load;
  assign o_ctr_clr  = r_ctr_clr;
  assign o_ctr_clk1 = r_ctr_clk1;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
  assign o_err      = r_err;
`endif

endmodule

// File: tb/tb_sn74ls197_sched.sv
// Bench for sn74ls197_sched with a behavioural sn74ls197 (q0 wired to clk2) on the counter pins.
module tb_sn74ls197_sched;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] req;
  logic [7:0] preset;
  logic [1:0] gnt, done;
  logic       busy, ctr_load, ctr_clr, ctr_clk1;
  logic [3:0] ctr_d, ctr_q, m_cnt;
  logic       stuck;
`ifdef SN74LS197_SCHED_TIMEOUT_EN
  logic       err;
`endif

  always #5 clk = ~clk;

  sn74ls197_sched #(.NREQ(2), .LOAD_CYC(2), .SETTLE(4)) dut (
    .i_clk      (clk),
    .i_clr      (clr),
    .i_req      (req),
    .i_preset   (preset),
    .o_gnt      (gnt),
    .o_done     (done),
    .o_busy     (busy),
    .o_ctr_d    (ctr_d),
    .o_ctr_load (ctr_load),
    .o_ctr_clr  (ctr_clr),
    .o_ctr_clk1 (ctr_clk1),
`ifdef SN74LS197_SCHED_TIMEOUT_EN
    .o_err      (err),
`endif
    .i_ctr_q    (ctr_q)
  );

  // Counter model: async clear, parallel load while load is low, count on clk1 falling edge.
  always @(negedge ctr_clk1 or negedge ctr_clr or negedge ctr_load) begin
    if (!ctr_clr)       m_cnt <= 4'h0;
    else if (!ctr_load) m_cnt <= ctr_d;
    else                m_cnt <= m_cnt + 4'h1;
  end
  assign ctr_q = stuck ? 4'h0 : m_cnt;

  int fall_cnt = 0;
  always @(negedge ctr_clk1) fall_cnt <= fall_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},      32'(gnt),      32'h0);
    chk({tag, "_done"},     32'(done),     32'h0);
    chk({tag, "_busy"},     32'(busy),     32'h0);
    chk({tag, "_ctr_d"},    32'(ctr_d),    32'h0);
    chk({tag, "_ctr_load"}, 32'(ctr_load), 32'h1);
    chk({tag, "_ctr_clr"},  32'(ctr_clr),  32'h0);
    chk({tag, "_ctr_clk1"}, 32'(ctr_clk1), 32'h1);
  endtask

  // One complete run; cycle 0 is the cycle in which req is first presented.
  task automatic run_one(input logic [1:0] r, input logic [3:0] p0, input logic [3:0] p1,
                         input int exp_idx, input int exp_done, input int exp_falls,
                         input string tag);
    int base, gnt_c, done_c, load_lo;
    logic [1:0] gnt_v, done_v;
    logic [3:0] q_at;
    gnt_c = -1; done_c = -1; load_lo = 0; gnt_v = '0; done_v = '0; q_at = '0;
    @(negedge clk);
    preset = {p1, p0};
    req    = r;
    base   = fall_cnt;
    for (int c = 1; c <= 200 && done_c < 0; c++) begin
      @(posedge clk); #1;
      if (gnt_c < 0 && gnt != 2'b00) begin gnt_c = c; gnt_v = gnt; end
      if (!ctr_load) load_lo++;
      if (done != 2'b00) begin done_c = c; done_v = done; q_at = ctr_q; end
    end
    chk({tag, "_gnt_cyc"},  32'(gnt_c),  32'd1);
    chk({tag, "_gnt_vec"},  32'(gnt_v),  32'(2'b01 << exp_idx));
    chk({tag, "_load_lo"},  32'(load_lo), 32'd2);
    chk({tag, "_done_cyc"}, 32'(done_c), 32'(exp_done));
    chk({tag, "_done_vec"}, 32'(done_v), 32'(2'b01 << exp_idx));
    chk({tag, "_falls"},    32'(fall_cnt - base), 32'(exp_falls));
    chk({tag, "_q_at_done"}, 32'(q_at), 32'hF);
    @(negedge clk);
    req = 2'b00;
    @(posedge clk); #1;
    chk({tag, "_idle_gnt"}, 32'(gnt),     32'h0);
    chk({tag, "_idle_clr"}, 32'(ctr_clr), 32'h0);
    chk({tag, "_idle_busy"}, 32'(busy),   32'h0);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] p0;
    logic [3:0] p1;
    int         idx;
    int         done_cyc;
    int         falls;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int seq[4];
    int n_g, n_d, base, gc, dc, hit;
    logic [1:0] prev_gnt, done0_seen;

    // done cycle = 8 + 6*(15-p), falls = 15-p; winner follows the pointer left by the previous row
    tbl[0] = '{2'b01, 4'hF, 4'h0, 0,  8,  0};
    tbl[1] = '{2'b01, 4'hC, 4'h0, 0, 26,  3};
    tbl[2] = '{2'b10, 4'h0, 4'hE, 1, 14,  1};
    tbl[3] = '{2'b11, 4'hA, 4'h7, 0, 38,  5};
    tbl[4] = '{2'b11, 4'h0, 4'h7, 1, 56,  8};
    tbl[5] = '{2'b01, 4'h0, 4'h3, 0, 98, 15};
    tbl[6] = '{2'b10, 4'h5, 4'hD, 1, 20,  2};

    clr = 1'b1; req = 2'b00; preset = 8'h00; stuck = 1'b0;
    #2 clr = 1'b0;
    #1 chk_reset("rst");
    @(negedge clk); @(negedge clk);
    clr = 1'b1;

    for (int i = 0; i < 7; i++)
      run_one(tbl[i].req, tbl[i].p0, tbl[i].p1, tbl[i].idx, tbl[i].done_cyc, tbl[i].falls,
              $sformatf("vec%0d", i));

    // Both requesting continuously: pointer was left at 1, so 0,1,0,1.
    @(negedge clk);
    preset = 8'hEE; req = 2'b11;
    n_g = 0; n_d = 0; prev_gnt = 2'b00;
    for (int c = 0; c < 120 && n_d < 4; c++) begin
      @(posedge clk); #1;
      if (prev_gnt == 2'b00 && gnt != 2'b00 && n_g < 4) begin
        seq[n_g] = (gnt == 2'b10) ? 1 : 0;
        n_g++;
      end
      prev_gnt = gnt;
      if (done != 2'b00) begin
        n_d++;
        if (n_d == 4) begin @(negedge clk); req = 2'b00; end
      end
    end
    chk("rr_runs", 32'(n_d), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("rr_grant%0d", k), 32'(seq[k]), 32'(k % 2));

    // Abort requester 0 after its second tick while requester 1 waits.
    @(negedge clk); @(negedge clk);
    preset = 8'hEC; req = 2'b11;
    base = fall_cnt; hit = 0;
    for (int c = 0; c < 60 && hit == 0; c++) begin
      @(posedge clk); #1;
      if (fall_cnt - base == 2) hit = 1;
    end
    chk("abort_reach_tick2", 32'(hit), 32'd1);
    chk("abort_gnt_before", 32'(gnt), 32'h1);
    @(negedge clk);
    req = 2'b10;
    @(posedge clk); #1;
    chk("abort_gnt",  32'(gnt),      32'h0);
    chk("abort_done", 32'(done),     32'h0);
    chk("abort_clr",  32'(ctr_clr),  32'h0);
    chk("abort_clk1", 32'(ctr_clk1), 32'h1);
    @(posedge clk); #1;
    chk("abort_next_gnt", 32'(gnt), 32'h2);
    gc = 0; dc = -1; done0_seen = 2'b00;
    for (int c = 1; c <= 40 && dc < 0; c++) begin
      @(posedge clk); #1;
      done0_seen |= done;
      if (done != 2'b00) dc = c;
    end
    chk("abort_next_done_cyc", 32'(dc), 32'd13);
    chk("abort_next_done_vec", 32'(done0_seen), 32'h2);
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);

    // Reset asserted while clk1 is low must restore clk1 and all other outputs at once.
    preset = 8'hEC; req = 2'b01;
    hit = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      @(posedge clk); #1;
      if (!ctr_clk1) hit = 1;
    end
    chk("rst_tick_reach", 32'(hit), 32'd1);
    #2 clr = 1'b0;
    #1 chk_reset("rst_tick");
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    clr = 1'b1;
    run_one(2'b01, 4'hC, 4'hE, 0, 26, 3, "post_rst");

`ifdef SN74LS197_SCHED_TIMEOUT_EN
    // Stuck counter: err one cycle after the CHECK that follows the 16th tick (cycle 6*16+7+1).
    @(negedge clk);
    stuck = 1'b1; preset = 8'h00; req = 2'b01;
    base = fall_cnt; dc = -1; gc = -1; done0_seen = 2'b00;
    for (int c = 1; c <= 200 && gc < 0; c++) begin
      @(posedge clk); #1;
      done0_seen |= done;
      if (err) begin gc = c; hit = busy; end
    end
    chk("to_err_cyc", 32'(gc), 32'd104);
    chk("to_falls",   32'(fall_cnt - base), 32'd16);
    chk("to_no_done", 32'(done0_seen), 32'h0);
    chk("to_busy",    32'(hit), 32'h0);
    @(negedge clk);
    req = 2'b00;
    @(posedge clk); #1;
    chk("to_err_pulse", 32'(err), 32'h0);
    stuck = 1'b0;
`else
    // Stuck counter without timeout: grant is held until the requester gives up.
    @(negedge clk);
    stuck = 1'b1; preset = 8'h00; req = 2'b01;
    done0_seen = 2'b00;
    for (int c = 1; c <= 150; c++) begin
      @(posedge clk); #1;
      done0_seen |= done;
    end
    chk("stuck_no_done", 32'(done0_seen), 32'h0);
    chk("stuck_gnt",     32'(gnt),  32'h1);
    chk("stuck_busy",    32'(busy), 32'h1);
    @(negedge clk);
    req = 2'b00;
    @(posedge clk); #1;
    chk("stuck_release_gnt", 32'(gnt), 32'h0);
    stuck = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
